// File: rtl/reg_wb_queue_if.sv
// reg_wb_queue_if: request, register-file write and operand-fetch signals of the writeback queue
interface reg_wb_queue_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 3,
   parameter int DW    = 16
);
   localparam int CW = $clog2(DEPTH + 1);
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic          drain_hold;
   logic          rf_wr_en;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;
   logic [AW-1:0] rd0_addr;
   logic [AW-1:0] rd1_addr;
   logic [DW-1:0] rf_rd0_data;
   logic [DW-1:0] rf_rd1_data;
   logic [DW-1:0] rd0_data;
   logic [DW-1:0] rd1_data;
   logic          rd0_pend;
   logic          rd1_pend;
   logic [CW-1:0] count;
   modport master (
      output in_valid, in_addr, in_data, drain_hold, rd0_addr, rd1_addr, rf_rd0_data, rf_rd1_data,
      input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rd0_data, rd1_data, rd0_pend, rd1_pend, count
   );
   modport slave (
      input  in_valid, in_addr, in_data, drain_hold, rd0_addr, rd1_addr, rf_rd0_data, rf_rd1_data,
      output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rd0_data, rd1_data, rd0_pend, rd1_pend, count
   );
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback FIFO in front of the register file write port with hazard lookup; WB_BYPASS_EN forwards hits instead of flagging them
module reg_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 3,
   parameter int DW    = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   reg_wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [AW-1:0] q_addr [DEPTH];
   logic [DW-1:0] q_data [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, idx;
   logic [CW-1:0] cnt;
   logic          push, pop, wr_en, hit0, hit1;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data, fwd0, fwd1;
   assign bus.in_ready   = cnt != CW'(DEPTH);
   assign push           = bus.in_valid & bus.in_ready;
   assign pop            = (cnt != '0) & ~bus.drain_hold;
   assign bus.count      = cnt;
   assign bus.rf_wr_en   = wr_en;
   assign bus.rf_wr_addr = wr_addr;
   assign bus.rf_wr_data = wr_data;
   // queue storage, written at the tail on every accepted request; not reset
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= bus.in_addr;
         q_data[wr_ptr] <= bus.in_data;
      end
   end
   // pointers, occupancy and the registered write port; a pop only sees entries stored before this edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         cnt   <= cnt + CW'(push) - CW'(pop);
         wr_en <= pop;
         if (pop) begin
            wr_addr <= q_addr[rd_ptr];
            wr_data <= q_data[rd_ptr];
         end
      end
   end
   // hazard search: output stage first, then queue oldest to newest so the newest match wins
   always_comb begin
      hit0 = 1'b0;
      hit1 = 1'b0;
      fwd0 = bus.rf_rd0_data;
      fwd1 = bus.rf_rd1_data;
      idx  = '0;
      if (wr_en && wr_addr == bus.rd0_addr) begin
         hit0 = 1'b1;
         fwd0 = wr_data;
      end
      if (wr_en && wr_addr == bus.rd1_addr) begin
         hit1 = 1'b1;
         fwd1 = wr_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (CW'(i) < cnt && q_addr[idx] == bus.rd0_addr) begin
            hit0 = 1'b1;
            fwd0 = q_data[idx];
         end
         if (CW'(i) < cnt && q_addr[idx] == bus.rd1_addr) begin
            hit1 = 1'b1;
            fwd1 = q_data[idx];
         end
      end
   end
`ifdef WB_BYPASS_EN
   assign bus.rd0_pend = 1'b0;
   assign bus.rd1_pend = 1'b0;
   assign bus.rd0_data = fwd0;
   assign bus.rd1_data = fwd1;
`else
   assign bus.rd0_pend = hit0;
   assign bus.rd1_pend = hit1;
   assign bus.rd0_data = bus.rf_rd0_data;
   assign bus.rd1_data = bus.rf_rd1_data;
   logic unused_fwd;
   assign unused_fwd = ^{fwd0, fwd1};
`endif
endmodule
